// File: rtl/bcx_pkg.sv
// ============================================================================
// Module      : bcx_pkg
// Description : Shared block-store types, widths and loader FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcx_pkg;

    localparam int BLOCK_STATE_BITS = 352;
    localparam int MIDSTATE_BITS    = 256;
    localparam int TAIL_BITS        = 96;

    typedef logic [BLOCK_STATE_BITS-1:0] block_state_t;

    typedef struct packed {
        logic [MIDSTATE_BITS-1:0] midstate;
        logic [TAIL_BITS-1:0]     tail;
    } block_fields_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_e;

endpackage : bcx_pkg

`default_nettype wire

// File: rtl/beat_shift_assembler.sv
// ============================================================================
// Module      : beat_shift_assembler
// Description : Shadow register that collects big-endian beats by position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_shift_assembler #(
    parameter  int STATE_BITS = 352,
    parameter  int BYTE_W     = 8,
    localparam int NBEATS     = STATE_BITS / BYTE_W,
    localparam int CNT_W      = $clog2(NBEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_first_i,
    input  logic                  load_next_i,
    input  logic [BYTE_W-1:0]     data_i,
    output logic [STATE_BITS-1:0] shadow_o,
    output logic                  full_o
);

    logic [STATE_BITS-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    // full means the beat slot about to be written is the final one
    assign full_o   = (count_q == CNT_W'(NBEATS - 1));
    assign shadow_o = shadow_q;

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (load_first_i) begin
            shadow_d                          = '0;
            shadow_d[STATE_BITS-1 -: BYTE_W]  = data_i;
            count_d                           = CNT_W'(1);
        end else if (load_next_i) begin
            for (int k = 0; k < NBEATS; k++) begin
                if (count_q == CNT_W'(k)) begin
                    shadow_d[STATE_BITS-1-BYTE_W*k -: BYTE_W] = data_i;
                end
            end
            count_d = full_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

endmodule : beat_shift_assembler

`default_nettype wire

// File: rtl/block_store_writer.sv
// ============================================================================
// Module      : block_store_writer
// Description : Byte-stream loader that atomically publishes a block state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_store_writer
    import bcx_pkg::*;
#(
    parameter int STATE_BITS = BLOCK_STATE_BITS,
    parameter int BYTE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_start,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  blk_valid,
    output logic                  blk_new,
    output logic [STATE_BITS-1:0] blk_state,
    output logic                  loading,
    output logic                  err_framing
);

    loader_state_e         state_q, state_d;
    logic                  ready_q, ready_d;
    logic [STATE_BITS-1:0] blk_state_q, blk_state_d;
    logic                  blk_valid_q, blk_valid_d;
    logic                  blk_new_q, blk_new_d;
    logic                  loading_q, loading_d;
    logic                  err_q, err_d;

    logic                  w_accept;
    logic                  w_load_first;
    logic                  w_load_next;
    logic                  w_full;
    logic [STATE_BITS-1:0] w_shadow;

    assign w_accept = in_valid & ready_q;

    beat_shift_assembler #(
        .STATE_BITS (STATE_BITS),
        .BYTE_W     (BYTE_W)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .load_first_i (w_load_first),
        .load_next_i  (w_load_next),
        .data_i       (in_data),
        .shadow_o     (w_shadow),
        .full_o       (w_full)
    );

    always_comb begin
        state_d      = state_q;
        w_load_first = 1'b0;
        w_load_next  = 1'b0;
        err_d        = 1'b0;
        blk_new_d    = 1'b0;
        blk_state_d  = blk_state_q;
        blk_valid_d  = blk_valid_q;
        loading_d    = loading_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (in_start) begin
                        w_load_first = 1'b1;
                        loading_d    = 1'b1;
                        state_d      = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (in_start) begin
                        // restart: the new beat 0 overwrites the partial unit
                        w_load_first = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        w_load_next = 1'b1;
                        if (w_full) begin
                            state_d = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                blk_state_d = w_shadow;
                blk_valid_d = 1'b1;
                blk_new_d   = 1'b1;
                loading_d   = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d != COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            blk_state_q <= '0;
            blk_valid_q <= 1'b0;
            blk_new_q   <= 1'b0;
            loading_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            blk_state_q <= blk_state_d;
            blk_valid_q <= blk_valid_d;
            blk_new_q   <= blk_new_d;
            loading_q   <= loading_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = ready_q;
    assign blk_valid   = blk_valid_q;
    assign blk_new     = blk_new_q;
    assign blk_state   = blk_state_q;
    assign loading     = loading_q;
    assign err_framing = err_q;

endmodule : block_store_writer

`default_nettype wire

// File: tb/tb_block_store_writer.sv
// ============================================================================
// Module      : tb_block_store_writer
// Description : Randomized self-checking bench for block_store_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_store_writer;

    localparam int NB = 44;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_start = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic         blk_valid;
    logic         blk_new;
    logic [351:0] blk_state;
    logic         loading;
    logic         err_framing;

    int total = 0;
    int bad   = 0;
    int new_cnt = 0;
    int err_cnt = 0;
    int ready_low = 0;

    logic [7:0] unit_bytes [NB];

    block_store_writer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_start    (in_start),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .blk_valid   (blk_valid),
        .blk_new     (blk_new),
        .blk_state   (blk_state),
        .loading     (loading),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (blk_new === 1'b1)     new_cnt++;
        if (err_framing === 1'b1) err_cnt++;
        if (in_ready !== 1'b1)    ready_low++;
    end

    // Reference: first byte is the most significant byte of the unit
    function automatic logic [351:0] model_unit();
        logic [351:0] v = '0;
        for (int k = 0; k < NB; k++) v = {v[343:0], unit_bytes[k]};
        return v;
    endfunction

    function automatic logic [351:0] fill_unit(input logic [7:0] b);
        logic [351:0] v = '0;
        for (int k = 0; k < NB; k++) v = {v[343:0], b};
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns #1 after the edge that accepts it
    task automatic drive_beat(input logic st, input logic [7:0] d);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_start = st;
        in_data  = d;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic load_unit(input int gap_pct, output bit loading_ok);
        loading_ok = 1'b1;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    idle_cycle();
                    if (loading !== 1'b1) loading_ok = 1'b0;
                end
            end
            drive_beat(k == 0, unit_bytes[k]);
            if (loading !== 1'b1) loading_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_new !== 1'b0 ||
            blk_state !== '0 || loading !== 1'b0 || err_framing !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b v=%b new=%b st0=%b ld=%b err=%b required all 0",
                     in_ready, blk_valid, blk_new, (blk_state == '0), loading, err_framing);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_idle_framing();
        int e0 = err_cnt;
        drive_beat(1'b0, 8'h77);
        total++;
        if (err_framing !== 1'b1 || loading !== 1'b0 || blk_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_framing: err=%b ld=%b v=%b required 1 0 0",
                     err_framing, loading, blk_valid);
        end
        idle_cycle();
        idle_cycle();
        total++;
        if (err_cnt - e0 != 1 || blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_framing_after: errs=%0d v=%b rdy=%b required 1 0 1",
                     err_cnt - e0, blk_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int n0 = new_cnt;
        for (int k = 0; k < NB; k++) unit_bytes[k] = 8'(k);
        load_unit(0, ok);
        total++;
        if (blk_new !== 1'b0 || in_ready !== 1'b0 || loading !== 1'b1) begin
            bad++;
            $display("FAIL basic_commit_cycle: new=%b rdy=%b ld=%b required 0 0 1",
                     blk_new, in_ready, loading);
        end
        @(posedge clk);
        #1;
        total++;
        if (blk_new !== 1'b1 || blk_valid !== 1'b1 || loading !== 1'b0) begin
            bad++;
            $display("FAIL basic_new_pulse: new=%b v=%b ld=%b required 1 1 0",
                     blk_new, blk_valid, loading);
        end
        total++;
        if (blk_state[351:344] !== 8'h00 || blk_state[7:0] !== 8'h2B ||
            blk_state !== model_unit()) begin
            bad++;
            $display("FAIL basic_state: got %h required %h", blk_state, model_unit());
        end
        repeat (3) idle_cycle();
        total++;
        if (blk_new !== 1'b0 || blk_valid !== 1'b1 || new_cnt - n0 != 1) begin
            bad++;
            $display("FAIL basic_sticky: new=%b v=%b pulses=%0d required 0 1 1",
                     blk_new, blk_valid, new_cnt - n0);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        int n0;
        for (int r = 0; r < 3; r++) begin
            n0 = new_cnt;
            for (int k = 0; k < NB; k++) unit_bytes[k] = 8'($urandom);
            load_unit(50, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL gaps_loading[%0d]: loading dropped during load, required 1", r);
            end
            repeat (3) idle_cycle();
            total++;
            if (blk_state !== model_unit() || new_cnt - n0 != 1) begin
                bad++;
                $display("FAIL gaps_state[%0d]: got %h pulses=%0d required %h pulses=1",
                         r, blk_state, new_cnt - n0, model_unit());
            end
        end
    endtask

    task automatic test_back_to_back();
        int  r0 = ready_low;
        int  n0 = new_cnt;
        int  torn = 0;
        logic [351:0] a = fill_unit(8'hAA);
        logic [351:0] b = fill_unit(8'h55);
        for (int k = 0; k < NB; k++) drive_beat(k == 0, 8'hAA);
        for (int k = 0; k < NB; k++) begin
            drive_beat(k == 0, 8'h55);
            if (k < NB - 1 && blk_state !== a) torn++;
        end
        total++;
        if (torn != 0 || blk_state !== a) begin
            bad++;
            $display("FAIL b2b_hold_a: %0d beats saw state other than A, now %h", torn, blk_state);
        end
        @(posedge clk);
        #1;
        total++;
        if (blk_state !== b || blk_new !== 1'b1) begin
            bad++;
            $display("FAIL b2b_commit_b: got %h new=%b required %h new=1", blk_state, blk_new, b);
        end
        repeat (2) idle_cycle();
        total++;
        if (ready_low - r0 != 2 || new_cnt - n0 != 2) begin
            bad++;
            $display("FAIL b2b_ready_low: low=%0d pulses=%0d required 2 2",
                     ready_low - r0, new_cnt - n0);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int n0 = new_cnt;
        int e0 = err_cnt;
        for (int k = 0; k < 10; k++) drive_beat(k == 0, 8'($urandom));
        for (int k = 0; k < NB; k++) unit_bytes[k] = 8'h11;
        drive_beat(1'b1, 8'h11);
        total++;
        if (err_framing !== 1'b1 || loading !== 1'b1) begin
            bad++;
            $display("FAIL restart_err: err=%b ld=%b required 1 1", err_framing, loading);
        end
        for (int k = 1; k < NB; k++) drive_beat(1'b0, 8'h11);
        repeat (3) idle_cycle();
        total++;
        if (blk_state !== model_unit() || new_cnt - n0 != 1 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL restart_state: got %h pulses=%0d errs=%0d required %h 1 1",
                     blk_state, new_cnt - n0, err_cnt - e0, model_unit());
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        int n0;
        for (int k = 0; k < NB; k++) unit_bytes[k] = 8'($urandom);
        load_unit(0, ok);
        repeat (2) idle_cycle();
        for (int k = 0; k <= 20; k++) drive_beat(k == 0, 8'($urandom));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_new !== 1'b0 ||
            blk_state !== '0 || loading !== 1'b0 || err_framing !== 1'b0) begin
            bad++;
            $display("FAIL midload_reset: rdy=%b v=%b new=%b st0=%b ld=%b err=%b required all 0",
                     in_ready, blk_valid, blk_new, (blk_state == '0), loading, err_framing);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n0 = new_cnt;
        for (int k = 0; k < NB; k++) unit_bytes[k] = 8'($urandom);
        load_unit(25, ok);
        repeat (3) idle_cycle();
        total++;
        if (blk_state !== model_unit() || blk_valid !== 1'b1 || new_cnt - n0 != 1) begin
            bad++;
            $display("FAIL midload_reload: got %h v=%b pulses=%0d required %h 1 1",
                     blk_state, blk_valid, new_cnt - n0, model_unit());
        end
    endtask

    initial begin
        test_reset();
        test_idle_framing();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_restart();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule : tb_block_store_writer

`default_nettype wire
